reg_hazard_decode_stage: RTL

Parametrised decode stage for the 16-bit Thumb front end.
- Extracts source/destination register addresses and their valid flags from a wider instruction subset than the first-generation decoder, including hi-register ops and load/store immediate.
- Tracks in-flight register writes in a scoreboard and stalls RAW/WAW hazards.
- Registers the decoded result into a one-entry valid/ready pipeline stage between fetch and execute.

---
 rtl/reg_hazard_decode_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/reg_hazard_decode_stage.sv
// Thumb-16 decode stage: register field extraction, RAW/WAW scoreboard and a one-entry output register.
// Optional macro REG_HAZARD_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module reg_hazard_decode_stage #(
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 16,
   parameter int PC_REG_NUM = 15,
   parameter int LR_REG_NUM = 14
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [15:0]           instr_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [15:0]           instr_o,
   output logic [ADDR_WIDTH-1:0] rs1_addr_o,
   output logic [ADDR_WIDTH-1:0] rs2_addr_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  rs1_valid_o,
   output logic                  rs2_valid_o,
   output logic                  rd_valid_o,
   input  logic                  wb_valid_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic                  flush_i,
   output logic [NUM_REGS-1:0]   pending_o
);

   localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_REG_NUM);
   localparam logic [ADDR_WIDTH-1:0] LR_ADDR = ADDR_WIDTH'(LR_REG_NUM);
   localparam logic [ADDR_WIDTH-1:0] ZERO_A  = {ADDR_WIDTH{1'b0}};

   logic                  rs1_v_s, rs2_v_s, rd_v_s;
   logic [ADDR_WIDTH-1:0] rs1_s, rs2_s, rd_s;
   logic [ADDR_WIDTH-1:0] rdn_s, rm_s;
   logic [NUM_REGS-1:0]   pending_q, pending_d, pend_eff_s;
   logic                  hazard_s, accept_s;

   assign rdn_s = ADDR_WIDTH'({instr_i[7], instr_i[2:0]});
   assign rm_s  = ADDR_WIDTH'(instr_i[6:3]);

   // Register field decode of the presented instruction
   always_comb begin
      rs1_v_s = 1'b0; rs2_v_s = 1'b0; rd_v_s = 1'b0;
      rs1_s = ZERO_A; rs2_s = ZERO_A; rd_s = ZERO_A;
      if (instr_i[15:13] == 3'b000 && instr_i[12:11] != 2'b11) begin
         rs1_v_s = 1'b1; rs1_s = ADDR_WIDTH'(instr_i[5:3]);
         rd_v_s  = 1'b1; rd_s  = ADDR_WIDTH'(instr_i[2:0]);
      end else if (instr_i[15:11] == 5'b00011) begin
         rs1_v_s = 1'b1; rs1_s = ADDR_WIDTH'(instr_i[5:3]);
         rd_v_s  = 1'b1; rd_s  = ADDR_WIDTH'(instr_i[2:0]);
         if (!instr_i[10]) begin
            rs2_v_s = 1'b1; rs2_s = ADDR_WIDTH'(instr_i[8:6]);
         end else begin
            rs2_v_s = 1'b0;
         end
      end else if (instr_i[15:13] == 3'b001) begin
         case (instr_i[12:11])
            2'b00:   begin rd_v_s = 1'b1; rd_s = ADDR_WIDTH'(instr_i[10:8]); end
            2'b01:   begin rs1_v_s = 1'b1; rs1_s = ADDR_WIDTH'(instr_i[10:8]); end
            default: begin
               rs1_v_s = 1'b1; rs1_s = ADDR_WIDTH'(instr_i[10:8]);
               rd_v_s  = 1'b1; rd_s  = ADDR_WIDTH'(instr_i[10:8]);
            end
         endcase
      end else if (instr_i[15:10] == 6'b010000) begin
         rs1_v_s = 1'b1; rs1_s = ADDR_WIDTH'(instr_i[2:0]);
         rs2_v_s = 1'b1; rs2_s = ADDR_WIDTH'(instr_i[5:3]);
         // TST/CMP/CMN only set flags
         if (instr_i[9:6] == 4'b1000 || instr_i[9:6] == 4'b1010 || instr_i[9:6] == 4'b1011) begin
            rd_v_s = 1'b0;
         end else begin
            rd_v_s = 1'b1; rd_s = ADDR_WIDTH'(instr_i[2:0]);
         end
      end else if (instr_i[15:10] == 6'b010001) begin
         case (instr_i[9:8])
            2'b00: begin
               rs1_v_s = 1'b1; rs1_s = rdn_s;
               rs2_v_s = 1'b1; rs2_s = rm_s;
               rd_v_s  = 1'b1; rd_s  = rdn_s;
            end
            2'b01: begin
               rs1_v_s = 1'b1; rs1_s = rdn_s;
               rs2_v_s = 1'b1; rs2_s = rm_s;
            end
            2'b10: begin
               rs2_v_s = 1'b1; rs2_s = rm_s;
               rd_v_s  = 1'b1; rd_s  = rdn_s;
            end
            default: begin
               rs1_v_s = 1'b1; rs1_s = rm_s;
               if (instr_i[7]) begin
                  rd_v_s = 1'b1; rd_s = LR_ADDR;
               end else begin
                  rd_v_s = 1'b0;
               end
            end
         endcase
      end else if (instr_i[15:11] == 5'b01001) begin
         rs1_v_s = 1'b1; rs1_s = PC_ADDR;
         rd_v_s  = 1'b1; rd_s  = ADDR_WIDTH'(instr_i[10:8]);
      end else if (instr_i[15:12] == 4'b0110) begin
         rs1_v_s = 1'b1; rs1_s = ADDR_WIDTH'(instr_i[5:3]);
         if (instr_i[11]) begin
            rd_v_s = 1'b1; rd_s = ADDR_WIDTH'(instr_i[2:0]);
         end else begin
            rs2_v_s = 1'b1; rs2_s = ADDR_WIDTH'(instr_i[2:0]);
         end
      end else begin
         rs1_v_s = 1'b0;
      end
   end

`ifdef REG_HAZARD_WB_BYPASS_EN
   assign pend_eff_s = pending_q & ~(wb_valid_i ? (NUM_REGS'(1'b1) << wb_addr_i) : {NUM_REGS{1'b0}});
`else
   assign pend_eff_s = pending_q;
`endif

   assign hazard_s = in_valid_i &
                     ((rs1_v_s & pend_eff_s[rs1_s] & (rs1_s != PC_ADDR)) |
                      (rs2_v_s & pend_eff_s[rs2_s] & (rs2_s != PC_ADDR)) |
                      (rd_v_s  & pend_eff_s[rd_s]));
   assign in_ready_o = (~out_valid_o | out_ready_i) & ~hazard_s & ~flush_i;
   assign accept_s   = in_valid_i & in_ready_o;

   // Scoreboard next state: clears first so a same-cycle set wins
   always_comb begin
      pending_d = pending_q;
      if (wb_valid_i) begin
         pending_d[wb_addr_i] = 1'b0;
      end else begin
         pending_d = pending_d;
      end
      if (flush_i && out_valid_o && rd_valid_o) begin
         pending_d[rd_addr_o] = 1'b0;
      end else begin
         pending_d = pending_d;
      end
      if (accept_s && rd_v_s && rd_s != PC_ADDR) begin
         pending_d[rd_s] = 1'b1;
      end else begin
         pending_d = pending_d;
      end
   end

   // Scoreboard and output entry registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q   <= {NUM_REGS{1'b0}};
         out_valid_o <= 1'b0;
         instr_o     <= 16'h0000;
         rs1_addr_o  <= ZERO_A;
         rs2_addr_o  <= ZERO_A;
         rd_addr_o   <= ZERO_A;
         rs1_valid_o <= 1'b0;
         rs2_valid_o <= 1'b0;
         rd_valid_o  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         if (flush_i) begin
            out_valid_o <= 1'b0;
         end else if (accept_s) begin
            out_valid_o <= 1'b1;
            instr_o     <= instr_i;
            rs1_addr_o  <= rs1_s;
            rs2_addr_o  <= rs2_s;
            rd_addr_o   <= rd_s;
            rs1_valid_o <= rs1_v_s;
            rs2_valid_o <= rs2_v_s;
            rd_valid_o  <= rd_v_s;
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

   assign pending_o = pending_q;

endmodule
